// File: rtl/gray_pkg.sv
// Shared Gray-code definitions used by the counter, the converters and the checkers.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  // Generic 32-bit conversion; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_conv.sv
// Purely combinational binary-to-Gray converter.
module bin2gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_count_gen.sv
// Up/down counter holding a binary count and a Gray copy registered from the same next state.
module gray_count_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_bin_out,
  output logic [WIDTH-1:0] o_gray_out,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    case ({i_load, i_en, i_up_dn})
      3'b100, 3'b101, 3'b110, 3'b111: begin
        w_bin_next  = i_load_val;
        w_wrap_next = 1'b0;
      end
      3'b011: begin
        w_bin_next  = r_bin + ONE_V;
        w_wrap_next = (r_bin == MAX_V);
      end
      3'b010: begin
        w_bin_next  = r_bin - ONE_V;
        w_wrap_next = (r_bin == ZERO_V);
      end
      default: begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
      end
    endcase
  end

  bin2gray_conv #(.WIDTH(WIDTH)) u_conv (
    .i_bin  (w_bin_next),
    .o_gray (w_gray_next)
  );

  // Output registers; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin  <= ZERO_V;
      r_gray <= ZERO_V;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_bin_out  = r_bin;
  assign o_gray_out = r_gray;
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_gray_count_gen.sv
// Directed and random checks of gray_count_gen against an arithmetic reference model.
module tb_gray_count_gen;
  import gray_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         wrap;

  int checks = 0;
  int failures = 0;
  int m_bin = 0;
  int m_wrap = 0;
  int gray_seq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_count_gen #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up_dn    (up_dn),
    .i_load     (load),
    .i_load_val (load_val),
    .o_bin_out  (bin_out),
    .o_gray_out (gray_out),
    .o_wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic u,
                      input logic l, input int v);
    int old_gray;
    bit is_count;
    rst = r; en = e; up_dn = u; load = l; load_val = v[W-1:0];
    old_gray = m_bin ^ (m_bin >> 1);
    is_count = !r && !l && e;
    @(posedge clk);
    if (r) begin
      m_bin = 0; m_wrap = 0;
    end else if (l) begin
      m_bin = v % MOD; m_wrap = 0;
    end else if (e && u) begin
      m_wrap = (m_bin == MOD - 1) ? 1 : 0;
      m_bin = (m_bin + 1) % MOD;
    end else if (e) begin
      m_wrap = (m_bin == 0) ? 1 : 0;
      m_bin = (m_bin + MOD - 1) % MOD;
    end else begin
      m_wrap = 0;
    end
    #1;
    chk("model_bin", int'(bin_out), m_bin);
    chk("model_gray", int'(gray_out), m_bin ^ (m_bin >> 1));
    chk("model_wrap", int'(wrap), m_wrap);
    chk("invariant", int'(gray_out), int'(bin2gray(32'(bin_out)) & 32'hF));
    if (is_count) chk("hamming", $countones(old_gray[W-1:0] ^ gray_out), 1);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1, 7);
    chk("reset_bin", int'(bin_out), 0);
    chk("reset_gray", int'(gray_out), 0);
    chk("reset_wrap", int'(wrap), 0);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 0);
      chk("up_seq_gray", int'(gray_out), gray_seq[(i + 1) % 16]);
      chk("up_seq_wrap", int'(wrap), (i == 15) ? 1 : 0);
    end

    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("down_wrap_bin", int'(bin_out), 15);
    chk("down_wrap_gray", int'(gray_out), 8);
    chk("down_wrap_pulse", int'(wrap), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("down2_bin", int'(bin_out), 14);
    chk("down2_gray", int'(gray_out), 9);
    chk("down2_wrap", int'(wrap), 0);

    step(1'b0, 1'b1, 1'b1, 1'b1, 10);
    chk("load_bin", int'(bin_out), 10);
    chk("load_gray", int'(gray_out), 15);
    chk("load_wrap", int'(wrap), 0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("hold_bin", int'(bin_out), 5);
      chk("hold_gray", int'(gray_out), 7);
      chk("hold_wrap", int'(wrap), 0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("resume_bin", int'(bin_out), 6);
    chk("resume_gray", int'(gray_out), 5);

    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("pre_rst_bin", int'(bin_out), 9);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("mid_rst_bin", int'(bin_out), 0);
    chk("mid_rst_gray", int'(gray_out), 0);
    chk("mid_rst_wrap", int'(wrap), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("post_rst_bin", int'(bin_out), 1);
    chk("post_rst_gray", int'(gray_out), 1);

    step(1'b0, 1'b0, 1'b0, 1'b1, 15);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("up_wrap_bin", int'(bin_out), 0);
    chk("up_wrap_gray", int'(gray_out), 0);
    chk("up_wrap_pulse", int'(wrap), 1);

    // Random mix weighted toward counting so both wrap directions occur.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, MOD - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
